// File: rtl/wbu_pkg.sv
// Shared definitions for the wbubus execution stage.
// - Command opcodes, found in codeword bits [35:32]
// - Result prefixes, placed in result codeword bits [35:32]
// - Execution state enumeration
package wbu_pkg;

  localparam logic [3:0] CMD_SETADDR = 4'h0;
  localparam logic [3:0] CMD_WRITE   = 4'h4;
  localparam logic [3:0] CMD_READ    = 4'h8;

  localparam logic [3:0] RSP_ADDR    = 4'h1;
  localparam logic [3:0] RSP_WRACK   = 4'h2;
  localparam logic [3:0] RSP_RDATA   = 4'h3;
  localparam logic [3:0] RSP_BUSERR  = 4'h5;
  localparam logic [3:0] RSP_BADCMD  = 4'h7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT   = 2'd2,
    S_RESULT = 2'd3
  } wbu_state_t;

endpackage

// File: rtl/wbuwatchdog.sv
// Bus watchdog: up-counter that saturates at all-ones and flags expiry there.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_clear         restart the count from zero (has priority over i_run)
//   i_run           count this cycle
//   o_expired       count has reached 2^LGTIMEOUT-1
module wbuwatchdog #(
  parameter int LGTIMEOUT = 20
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [LGTIMEOUT-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_count <= '0;
    else if (i_run && !o_expired)
      r_count <= r_count + LGTIMEOUT'(1);
  end

  assign o_expired = &r_count;

endmodule

// File: rtl/wbuexec.sv
// Bus-execution stage of the wbubus debug bridge. Executes 36-bit command
// codewords as single pipelined Wishbone transactions (one outstanding at a
// time) and returns each outcome as a 36-bit result codeword.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_stb, i_codword, o_busy   command codeword input and backpressure
//   o_wb_*                     Wishbone pipelined master outputs
//   i_wb_stall/ack/err/data    Wishbone slave responses
//   o_stb, o_codword, i_busy   result codeword output and backpressure
//   o_active                   command in progress or result pending
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | waiting for a command codeword
// S_REQ    | strobe asserted, waiting for the slave to take it
// S_WAIT   | request taken, waiting for ack / err / watchdog
// S_RESULT | result codeword offered downstream until accepted
module wbuexec
  import wbu_pkg::*;
#(
  parameter int AW        = 30,
  parameter int LGTIMEOUT = 20
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_stb,
  output logic          o_busy,
  input  logic [35:0]   i_codword,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  output logic [3:0]    o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic          o_stb,
  input  logic          i_busy,
  output logic [35:0]   o_codword,
  output logic          o_active
);

  wbu_state_t    r_state, w_next;
  logic [AW-1:0] r_addr;
  logic          r_inc;
  logic          r_we;
  logic [31:0]   r_wdata;
  logic [9:0]    r_cnt;   // burst reads still to issue after the current one
  logic          r_keep;  // hold cyc through RESULT; cleared when the bus errs
  logic [35:0]   r_rsp;
  logic          w_accept;
  logic          w_expired;
  logic          w_wd_clear;
  logic          w_wd_run;

  assign w_accept   = i_stb && (r_state == S_IDLE);
  assign w_wd_clear = (w_next == S_REQ) && (r_state != S_REQ);
  assign w_wd_run   = (r_state == S_REQ) || (r_state == S_WAIT);

  wbuwatchdog #(.LGTIMEOUT(LGTIMEOUT)) u_watchdog (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_wd_clear),
    .i_run    (w_wd_run),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (w_accept) begin
          if (i_codword[35:32] == CMD_WRITE || i_codword[35:32] == CMD_READ)
            w_next = S_REQ;
          else
            w_next = S_RESULT;
        end
      // An endlessly stalled slave must not hang the bridge either
      S_REQ:
        if (w_expired)
          w_next = S_RESULT;
        else if (!i_wb_stall)
          w_next = S_WAIT;
      S_WAIT:
        if (i_wb_err || w_expired || i_wb_ack)
          w_next = S_RESULT;
      S_RESULT:
        if (!i_busy)
          w_next = (r_keep && r_cnt != 10'd0) ? S_REQ : S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr  <= '0;
      r_inc   <= 1'b1;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_keep  <= 1'b0;
      r_rsp   <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_accept) begin
            case (i_codword[35:32])
              CMD_SETADDR: begin
                r_addr <= i_codword[AW-1:0];
                r_inc  <= i_codword[31];
                r_rsp  <= {RSP_ADDR, 32'(i_codword[AW-1:0])};
                r_keep <= 1'b0;
              end
              CMD_WRITE: begin
                r_we    <= 1'b1;
                r_wdata <= i_codword[31:0];
                r_cnt   <= '0;
              end
              CMD_READ: begin
                r_we  <= 1'b0;
                r_cnt <= i_codword[9:0];
              end
              default: begin
                r_rsp  <= {RSP_BADCMD, 32'h0};
                r_keep <= 1'b0;
              end
            endcase
          end
        S_REQ:
          if (w_expired) begin
            r_rsp  <= {RSP_BUSERR, 32'h0};
            r_cnt  <= '0;
            r_keep <= 1'b0;
          end
        S_WAIT:
          // err outranks a simultaneous ack
          if (i_wb_err || w_expired) begin
            r_rsp  <= {RSP_BUSERR, 32'h0};
            r_cnt  <= '0;
            r_keep <= 1'b0;
          end else if (i_wb_ack) begin
            r_rsp  <= r_we ? {RSP_WRACK, 32'h0} : {RSP_RDATA, i_wb_data};
            r_addr <= r_addr + AW'(r_inc);
            r_keep <= 1'b1;
          end
        S_RESULT:
          if (!i_busy) begin
            if (r_keep && r_cnt != 10'd0)
              r_cnt <= r_cnt - 10'd1;
            else
              r_keep <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  assign o_busy    = (r_state != S_IDLE);
  assign o_active  = i_stb || (r_state != S_IDLE);
  assign o_wb_stb  = (r_state == S_REQ);
  assign o_wb_cyc  = (r_state == S_REQ) || (r_state == S_WAIT) ||
                     ((r_state == S_RESULT) && r_keep);
  assign o_wb_we   = r_we && ((r_state == S_REQ) || (r_state == S_WAIT));
  assign o_wb_addr = r_addr;
  assign o_wb_data = r_wdata;
  assign o_wb_sel  = 4'hf;
  assign o_stb     = (r_state == S_RESULT);
  assign o_codword = r_rsp;

endmodule
